vga_axil_slave_bridge: RTL and testbench
========================================

# vga_axil_slave_bridge

Parametrised AXI4-Lite slave to native register/memory port bridge sitting between the interconnect and VGA register file or frame buffer. It generalises the fixed-width, simultaneous-AW/W slave FSM:
- parametrised data, address and native widths
- independent AW and W acceptance in either order
- byte strobes
- configurable native read latency
- SLVERR for out-of-range addresses

Read and write paths are fully independent FSMs sharing only clock and reset.

## Interface
- DATA_W, 32: AXI and native data width; 32 or 64.
- AXIL_ADDR_W, 32: AXI address width.
- NATIVE_ADDR_W, 16: native word-address width.
- NUM_WORDS, 2**NATIVE_ADDR_W: decoded words; word addresses >= NUM_WORDS are out of range.
- READ_LATENCY, 1: cycles from rd_en_o to valid rd_data_i; range 1..8.
- clk_i  in  1  clock.
- arst_ni  in  1  asynchronous active-low reset.
- awaddr_i in AXIL_ADDR_W; awvalid_i in 1; awready_o out 1: write address channel.
- wdata_i in DATA_W; wstrb_i in DATA_W/8; wvalid_i in 1; wready_o out 1: write data channel.
- bresp_o out 2; bvalid_o out 1; bready_i in 1: write response.
- araddr_i in AXIL_ADDR_W; arvalid_i in 1; arready_o out 1: read address.
- rdata_o out DATA_W; rresp_o out 2; rvalid_o out 1; rready_i in 1: read data.
- wr_en_o out 1; wr_addr_o out NATIVE_ADDR_W; wr_data_o out DATA_W; wr_strb_o out DATA_W/8: native write, single-cycle pulse.
- rd_en_o out 1; rd_addr_o out NATIVE_ADDR_W; rd_data_i in DATA_W: native read.

## Operation
- Word address = axil_addr >> log2(DATA_W/8), truncated to NATIVE_ADDR_W after the range check. Low address bits are ignored.
- Write FSM states: WIdle, WHaveAddr, WHaveData, WExec, WResp.
  - WIdle: awready=wready=1. AW+W same cycle -> WExec. AW only -> WHaveAddr (awready=0). W only -> WHaveData (wready=0).
  - WHaveAddr -> WExec on W handshake. WHaveData -> WExec on AW handshake.
  - WExec lasts one cycle: wr_en_o=1 if in range, otherwise 0. Then -> WResp.
  - WResp: bvalid=1 until bready; -> WIdle.
- Read FSM states: RIdle, RExec, RWait, RResp.
  - RIdle (arready=1) -> RExec on AR handshake.
  - RExec lasts one cycle: rd_en_o=1 if in range. Then -> RWait.
  - RWait counts READ_LATENCY-1 cycles, then captures rd_data_i (in range) or 0 (out of range) into rdata, and -> RResp.
  - RResp: rvalid=1 until rready; -> RIdle.
- bresp/rresp: OKAY (2'b00) in range, SLVERR (2'b10) out of range. rresp and rdata are held stable while rvalid=1.
- Only one outstanding transaction per direction. Read and write may be in flight and hit the native port in the same cycle; the bridge does no ordering or arbitration.
- wr_addr/wr_data/wr_strb/rd_addr are registered at capture and held until the next capture.

## Timing
- All outputs are registered. Under reset every output is 0, including the ready signals.
- awready/wready/arready rise on the first clock edge after reset release.
- Write with AW+W in cycle 0: wr_en_o in cycle 1, bvalid in cycle 2. Minimum 3 cycles per write when bready is tied high.
- Write with AW in cycle 0 and W in cycle k: wr_en_o in cycle k+1.
- Read with AR in cycle 0: rd_en_o in cycle 1, rd_data_i sampled at the end of cycle READ_LATENCY, rvalid in cycle READ_LATENCY+1.
- Ready signals drop in the cycle after a handshake and reassert in the cycle after the B/R handshake.
- Reset mid-transaction drops the transaction immediately. No native pulse or response is emitted afterwards.

## Structure
- vga_axil_pkg gains:
  - axil_resp_t with OKAY and SLVERR
  - parametrised axil2native_addr and in_range functions
- Read latency counter: width $clog2(READ_LATENCY+1).
- One natural sub-module: vga_axil_bridge_rd, the read FSM with its latency counter. The write FSM stays inline.

## Test plan
- AW+W same cycle, addr 0x10, data 0xDEADBEEF, wstrb 4'hF -> wr_en_o cycle 1 with wr_addr 4, bvalid cycle 2 with bresp OKAY.
- W at cycle 0, AW at cycle 3 (addr 0x8, wstrb 4'b0101) -> wr_en_o cycle 4, addr 2, strb 4'b0101. wready low in cycles 1..5.
- READ_LATENCY=3, read addr 0x20, rd_data_i=0x12345678 in cycle 3 -> rd_en_o cycle 1, rdata 0x12345678 with rvalid from cycle 4.
- NUM_WORDS=16, write and read at addr 0x40 -> no wr_en/rd_en, bresp=rresp=SLVERR, rdata 0.
- rready held low 5 cycles -> rvalid and rdata stable, arready low. Concurrent write completes independently.
- arst_ni pulsed low during RWait -> rvalid stays 0, arready=1 the cycle after release, no late rd_data capture.

Source files
------------

// File: rtl/vga_axil_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_axil_pkg
//  Description : Shared types and address helpers for the AXI4-Lite to
//                native register/memory port bridge.
//  Revision    : 1.0 - initial release
// ============================================================================
package vga_axil_pkg;

    // AXI response codes used by the bridge
    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } axil_resp_t;

    // Write channel FSM states
    typedef enum logic [2:0] {
        W_IDLE      = 3'd0,
        W_HAVE_ADDR = 3'd1,
        W_HAVE_DATA = 3'd2,
        W_EXEC      = 3'd3,
        W_RESP      = 3'd4
    } wr_state_t;

    // Read channel FSM states
    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_EXEC = 2'd1,
        R_WAIT = 2'd2,
        R_RESP = 2'd3
    } rd_state_t;

    // Address arithmetic is done at a fixed wide width so one helper serves
    // every AXI address width up to 64 bits.
    localparam int unsigned ADDR_CALC_W = 64;

    // Byte address to word address: drop the byte-lane bits.
    function automatic logic [ADDR_CALC_W-1:0] axil2native_addr(
        input logic [ADDR_CALC_W-1:0] axil_addr,
        input int unsigned            byte_shift
    );
        return axil_addr >> byte_shift;
    endfunction

    // A word address is decoded only below the configured word count.
    function automatic logic in_range(
        input logic [ADDR_CALC_W-1:0] word_addr,
        input logic [ADDR_CALC_W-1:0] num_words
    );
        return (word_addr < num_words);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_axil_bridge_rd.sv
`default_nettype none
// ============================================================================
//  Module      : vga_axil_bridge_rd
//  Description : AXI4-Lite read channel FSM with native read latency counter.
//                One outstanding read; response data held while rvalid is up.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_axil_bridge_rd
    import vga_axil_pkg::*;
#(
    parameter int unsigned      DATA_W        = 32,
    parameter int unsigned      AXIL_ADDR_W   = 32,
    parameter int unsigned      NATIVE_ADDR_W = 16,
    parameter longint unsigned  NUM_WORDS     = 64'd1 << NATIVE_ADDR_W,
    parameter int unsigned      READ_LATENCY  = 1
) (
    input  logic                     clk_i,
    input  logic                     arst_ni,
    input  logic [AXIL_ADDR_W-1:0]   araddr_i,
    input  logic                     arvalid_i,
    output logic                     arready_o,
    output logic [DATA_W-1:0]        rdata_o,
    output logic [1:0]               rresp_o,
    output logic                     rvalid_o,
    input  logic                     rready_i,
    output logic                     rd_en_o,
    output logic [NATIVE_ADDR_W-1:0] rd_addr_o,
    input  logic [DATA_W-1:0]        rd_data_i
);

    localparam int unsigned BYTE_SHIFT  = $clog2(DATA_W / 8);
    localparam int unsigned CNT_W       = $clog2(READ_LATENCY + 1);
    // RWait spans READ_LATENCY-1 cycles; the counter runs down to zero.
    localparam int unsigned WAIT_CYCLES = (READ_LATENCY > 1) ? (READ_LATENCY - 2) : 0;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);

    rd_state_t              state;
    rd_state_t              state_next;
    logic [CNT_W-1:0]       wait_cnt;
    logic                   ar_hs;
    logic                   ar_ok;
    logic                   ar_ok_now;
    logic [ADDR_CALC_W-1:0] ar_word;

    assign ar_hs     = arvalid_i & arready_o;
    assign ar_word   = axil2native_addr(ADDR_CALC_W'(araddr_i), BYTE_SHIFT);
    assign ar_ok_now = in_range(ar_word, ADDR_CALC_W'(NUM_WORDS));

    // Next-state logic for the read channel.
    always_comb begin
        state_next = state;
        case (state)
            R_IDLE: if (ar_hs) state_next = R_EXEC;
            R_EXEC: state_next = (READ_LATENCY > 1) ? R_WAIT : R_RESP;
            R_WAIT: if (wait_cnt == '0) state_next = R_RESP;
            R_RESP: if (rvalid_o && rready_i) state_next = R_IDLE;
            default: state_next = R_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) state <= R_IDLE;
        else          state <= state_next;
    end

    // Latency counter: loaded during RExec, counts down through RWait.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            wait_cnt <= '0;
        end else if (state == R_EXEC) begin
            wait_cnt <= CNT_LOAD;
        end else if ((state == R_WAIT) && (wait_cnt != '0)) begin
            wait_cnt <= wait_cnt - 1'b1;
        end
    end

    // Capture the native address and its decode result at the AR handshake.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            rd_addr_o <= '0;
            ar_ok     <= 1'b0;
        end else if (ar_hs) begin
            rd_addr_o <= NATIVE_ADDR_W'(ar_word);
            ar_ok     <= ar_ok_now;
        end
    end

    // Registered channel outputs, derived from the state being entered.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            arready_o <= 1'b0;
            rd_en_o   <= 1'b0;
            rvalid_o  <= 1'b0;
            rdata_o   <= '0;
            rresp_o   <= OKAY;
        end else begin
            arready_o <= (state_next == R_IDLE);
            // RExec is only entered through an AR handshake, so the live
            // decode is the right one here.
            rd_en_o   <= (state_next == R_EXEC) && ar_ok_now;
            rvalid_o  <= (state_next == R_RESP);
            if ((state_next == R_RESP) && (state != R_RESP)) begin
                rdata_o <= ar_ok ? rd_data_i : '0;
                rresp_o <= ar_ok ? OKAY : SLVERR;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/vga_axil_slave_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : vga_axil_slave_bridge
//  Description : AXI4-Lite slave to native register/memory port bridge.
//                Write FSM accepts AW and W in either order; read path lives
//                in vga_axil_bridge_rd. The two directions are independent.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_axil_slave_bridge
    import vga_axil_pkg::*;
#(
    parameter int unsigned      DATA_W        = 32,
    parameter int unsigned      AXIL_ADDR_W   = 32,
    parameter int unsigned      NATIVE_ADDR_W = 16,
    parameter longint unsigned  NUM_WORDS     = 64'd1 << NATIVE_ADDR_W,
    parameter int unsigned      READ_LATENCY  = 1
) (
    input  logic                     clk_i,
    input  logic                     arst_ni,
    // write address
    input  logic [AXIL_ADDR_W-1:0]   awaddr_i,
    input  logic                     awvalid_i,
    output logic                     awready_o,
    // write data
    input  logic [DATA_W-1:0]        wdata_i,
    input  logic [DATA_W/8-1:0]      wstrb_i,
    input  logic                     wvalid_i,
    output logic                     wready_o,
    // write response
    output logic [1:0]               bresp_o,
    output logic                     bvalid_o,
    input  logic                     bready_i,
    // read address
    input  logic [AXIL_ADDR_W-1:0]   araddr_i,
    input  logic                     arvalid_i,
    output logic                     arready_o,
    // read data
    output logic [DATA_W-1:0]        rdata_o,
    output logic [1:0]               rresp_o,
    output logic                     rvalid_o,
    input  logic                     rready_i,
    // native write port
    output logic                     wr_en_o,
    output logic [NATIVE_ADDR_W-1:0] wr_addr_o,
    output logic [DATA_W-1:0]        wr_data_o,
    output logic [DATA_W/8-1:0]      wr_strb_o,
    // native read port
    output logic                     rd_en_o,
    output logic [NATIVE_ADDR_W-1:0] rd_addr_o,
    input  logic [DATA_W-1:0]        rd_data_i
);

    localparam int unsigned BYTE_SHIFT = $clog2(DATA_W / 8);

    wr_state_t              w_state;
    wr_state_t              w_next;
    logic                   aw_hs;
    logic                   w_hs;
    logic                   aw_ok;
    logic                   aw_ok_now;
    logic [ADDR_CALC_W-1:0] aw_word;

    assign aw_hs     = awvalid_i & awready_o;
    assign w_hs      = wvalid_i & wready_o;
    assign aw_word   = axil2native_addr(ADDR_CALC_W'(awaddr_i), BYTE_SHIFT);
    assign aw_ok_now = in_range(aw_word, ADDR_CALC_W'(NUM_WORDS));

    // Next-state logic for the write channel.
    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE: begin
                if (aw_hs && w_hs) w_next = W_EXEC;
                else if (aw_hs)    w_next = W_HAVE_ADDR;
                else if (w_hs)     w_next = W_HAVE_DATA;
            end
            W_HAVE_ADDR: if (w_hs)  w_next = W_EXEC;
            W_HAVE_DATA: if (aw_hs) w_next = W_EXEC;
            W_EXEC:                 w_next = W_RESP;
            W_RESP: if (bvalid_o && bready_i) w_next = W_IDLE;
            default:                w_next = W_IDLE;
        endcase
    end

    // Write state register.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) w_state <= W_IDLE;
        else          w_state <= w_next;
    end

    // Capture address/decode and data/strobes at their own handshakes.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            wr_addr_o <= '0;
            aw_ok     <= 1'b0;
            wr_data_o <= '0;
            wr_strb_o <= '0;
        end else begin
            if (aw_hs) begin
                wr_addr_o <= NATIVE_ADDR_W'(aw_word);
                aw_ok     <= aw_ok_now;
            end
            if (w_hs) begin
                wr_data_o <= wdata_i;
                wr_strb_o <= wstrb_i;
            end
        end
    end

    // Registered write-channel outputs, derived from the state being entered.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            awready_o <= 1'b0;
            wready_o  <= 1'b0;
            wr_en_o   <= 1'b0;
            bvalid_o  <= 1'b0;
            bresp_o   <= OKAY;
        end else begin
            awready_o <= (w_next == W_IDLE) || (w_next == W_HAVE_DATA);
            wready_o  <= (w_next == W_IDLE) || (w_next == W_HAVE_ADDR);
            // When AW completes in the same edge as entering WExec the
            // captured decode is not yet visible, so use the live one.
            wr_en_o   <= (w_next == W_EXEC) && (aw_hs ? aw_ok_now : aw_ok);
            bvalid_o  <= (w_next == W_RESP);
            if (w_state == W_EXEC) begin
                bresp_o <= aw_ok ? OKAY : SLVERR;
            end
        end
    end

    vga_axil_bridge_rd #(
        .DATA_W        (DATA_W),
        .AXIL_ADDR_W   (AXIL_ADDR_W),
        .NATIVE_ADDR_W (NATIVE_ADDR_W),
        .NUM_WORDS     (NUM_WORDS),
        .READ_LATENCY  (READ_LATENCY)
    ) u_rd (
        .clk_i     (clk_i),
        .arst_ni   (arst_ni),
        .araddr_i  (araddr_i),
        .arvalid_i (arvalid_i),
        .arready_o (arready_o),
        .rdata_o   (rdata_o),
        .rresp_o   (rresp_o),
        .rvalid_o  (rvalid_o),
        .rready_i  (rready_i),
        .rd_en_o   (rd_en_o),
        .rd_addr_o (rd_addr_o),
        .rd_data_i (rd_data_i)
    );

endmodule
`default_nettype wire

// File: tb/tb_vga_axil_slave_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_axil_slave_bridge
//  Description : Directed and randomized bench for vga_axil_slave_bridge with
//                a byte-addressed reference memory and a native memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_axil_slave_bridge;

    localparam int DATA_W        = 32;
    localparam int AXIL_ADDR_W   = 32;
    localparam int NATIVE_ADDR_W = 16;
    localparam int NUM_WORDS     = 16;
    localparam int READ_LATENCY  = 3;

    logic        clk = 1'b0;
    logic        arst_ni = 1'b1;
    logic [31:0] awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [31:0] araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic        rd_en;
    logic [15:0] rd_addr;
    logic [31:0] rd_data = '0;

    int total = 0;
    int bad   = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    int exp_wr_cnt = 0;
    int exp_rd_cnt = 0;

    logic [31:0] mem_dev [NUM_WORDS];
    logic [31:0] ref_mem [NUM_WORDS];

    always #5 clk = ~clk;

    vga_axil_slave_bridge #(
        .DATA_W        (DATA_W),
        .AXIL_ADDR_W   (AXIL_ADDR_W),
        .NATIVE_ADDR_W (NATIVE_ADDR_W),
        .NUM_WORDS     (NUM_WORDS),
        .READ_LATENCY  (READ_LATENCY)
    ) dut (
        .clk_i     (clk),
        .arst_ni   (arst_ni),
        .awaddr_i  (awaddr),
        .awvalid_i (awvalid),
        .awready_o (awready),
        .wdata_i   (wdata),
        .wstrb_i   (wstrb),
        .wvalid_i  (wvalid),
        .wready_o  (wready),
        .bresp_o   (bresp),
        .bvalid_o  (bvalid),
        .bready_i  (bready),
        .araddr_i  (araddr),
        .arvalid_i (arvalid),
        .arready_o (arready),
        .rdata_o   (rdata),
        .rresp_o   (rresp),
        .rvalid_o  (rvalid),
        .rready_i  (rready),
        .wr_en_o   (wr_en),
        .wr_addr_o (wr_addr),
        .wr_data_o (wr_data),
        .wr_strb_o (wr_strb),
        .rd_en_o   (rd_en),
        .rd_addr_o (rd_addr),
        .rd_data_i (rd_data)
    );

    // Native memory: applies write pulses, returns read data exactly
    // READ_LATENCY-1 cycles after rd_en and junk in every other cycle.
    logic        rd_pend = 1'b0;
    int          rd_cd   = 0;
    logic [15:0] rd_word = '0;
    always @(negedge clk) begin
        if (wr_en) begin
            wr_cnt++;
            for (int b = 0; b < 4; b++)
                if (wr_strb[b]) mem_dev[wr_addr[3:0]][8*b +: 8] = wr_data[8*b +: 8];
        end
        if (rd_en) begin
            rd_cnt++;
            rd_pend = 1'b1;
            rd_cd   = READ_LATENCY - 1;
            rd_word = rd_addr;
        end
        if (rd_pend && rd_cd == 0) begin
            rd_data = mem_dev[rd_word[3:0]];
            rd_pend = 1'b0;
        end else begin
            rd_data = 32'hBAAD_F00D;
            if (rd_pend) rd_cd--;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: byte address / 4 selects a word; only the first
    // NUM_WORDS words exist.
    function automatic logic model_in_range(input logic [31:0] a);
        return (a / 4) < 32'(NUM_WORDS);
    endfunction

    function automatic logic [1:0] model_resp(input logic [31:0] a);
        return model_in_range(a) ? 2'b00 : 2'b10;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        return model_in_range(a) ? ref_mem[a / 4] : 32'h0;
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        if (model_in_range(a)) begin
            exp_wr_cnt++;
            for (int b = 0; b < 4; b++)
                if (s[b]) ref_mem[a / 4][8*b +: 8] = d[8*b +: 8];
        end
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int w_dly, input logic [1:0] exp_resp);
        int   n;
        logic aw_done, w_done, aw_now, w_now;
        awaddr = a; wdata = d; wstrb = s;
        aw_done = 1'b0; w_done = 1'b0; n = 0;
        while (!(aw_done && w_done) && n < 40) begin
            awvalid = !aw_done && (n >= aw_dly);
            wvalid  = !w_done && (n >= w_dly);
            aw_now  = awvalid && awready;
            w_now   = wvalid && wready;
            step();
            n++;
            aw_done = aw_done | aw_now;
            w_done  = w_done | w_now;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        check("wr_handshake", {aw_done, w_done}, 2'b11);
        n = 0;
        while (!bvalid && n < 40) begin step(); n++; end
        check("wr_b_latency", n, 1);
        check("wr_bresp", bresp, exp_resp);
        bready = 1'b1;
        step();
        bready = 1'b0;
        check("wr_bvalid_drop", bvalid, 0);
        check("wr_ready_back", {awready, wready}, 2'b11);
    endtask

    task automatic axi_read(input logic [31:0] a, input int hold,
                            input logic [31:0] exp_data, input logic [1:0] exp_resp);
        int n;
        araddr = a; arvalid = 1'b1; n = 0;
        while (!arready && n < 40) begin step(); n++; end
        check("rd_ar_timeout", arready, 1);
        step();
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 40) begin step(); n++; end
        check("rd_latency", n, READ_LATENCY);
        for (int i = 0; i <= hold; i++) begin
            check("rd_rvalid", rvalid, 1);
            check("rd_rdata", rdata, exp_data);
            check("rd_rresp", rresp, exp_resp);
            check("rd_arready_busy", arready, 0);
            if (i == hold) rready = 1'b1;
            step();
        end
        rready = 1'b0;
        check("rd_rvalid_drop", rvalid, 0);
        check("rd_arready_back", arready, 1);
    endtask

    initial begin
        logic [31:0]  a, d;
        logic [3:0]   s;
        int unsigned  word;

        for (int i = 0; i < NUM_WORDS; i++) begin
            mem_dev[i] = '0;
            ref_mem[i] = '0;
        end

        // ---- reset state ----
        #1 arst_ni = 1'b0;
        step(); step();
        check("rst_ready", {awready, wready, arready}, 3'b000);
        check("rst_valid", {bvalid, rvalid, wr_en, rd_en}, 4'b0000);
        check("rst_rdata", rdata, 0);
        check("rst_resp", {bresp, rresp}, 4'b0000);
        arst_ni = 1'b1;
        check("rst_ready_at_release", {awready, wready, arready}, 3'b000);
        step();
        check("ready_after_release", {awready, wready, arready}, 3'b111);

        // ---- AW+W same cycle ----
        awaddr = 32'h10; wdata = 32'hDEADBEEF; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        check("t1_wr_en_c1", wr_en, 1);
        check("t1_wr_addr", wr_addr, 4);
        check("t1_wr_data", wr_data, 32'hDEADBEEF);
        check("t1_wr_strb", wr_strb, 4'hF);
        check("t1_bvalid_c1", bvalid, 0);
        check("t1_ready_c1", {awready, wready}, 2'b00);
        step();
        check("t1_bvalid_c2", bvalid, 1);
        check("t1_bresp_c2", bresp, 2'b00);
        check("t1_wr_en_c2", wr_en, 0);
        step();
        check("t1_bvalid_c3", bvalid, 0);
        check("t1_ready_c3", {awready, wready}, 2'b11);
        bready = 1'b0;
        model_write(32'h10, 32'hDEADBEEF, 4'hF);

        // ---- W first, AW three cycles later ----
        awaddr = 32'h8; wdata = 32'hA1B2C3D4; wstrb = 4'b0101; bready = 1'b1;
        for (int c = 0; c <= 6; c++) begin
            wvalid  = (c == 0);
            awvalid = (c == 3);
            check("t2_wready", wready, (c >= 1 && c <= 5) ? 0 : 1);
            check("t2_wr_en", wr_en, (c == 4) ? 1 : 0);
            check("t2_bvalid", bvalid, (c == 5) ? 1 : 0);
            if (c == 4) begin
                check("t2_wr_addr", wr_addr, 2);
                check("t2_wr_strb", wr_strb, 4'b0101);
                check("t2_wr_data", wr_data, 32'hA1B2C3D4);
            end
            step();
        end
        wvalid = 1'b0; awvalid = 1'b0; bready = 1'b0;
        model_write(32'h8, 32'hA1B2C3D4, 4'b0101);

        // ---- latency-3 read with stalled rready, concurrent write ----
        axi_write(32'h20, 32'h12345678, 4'hF, 0, 0, 2'b00);
        model_write(32'h20, 32'h12345678, 4'hF);
        araddr = 32'h20; awaddr = 32'h4; wdata = 32'h0BADCAFE; wstrb = 4'hF;
        bready = 1'b1;
        for (int c = 0; c <= 10; c++) begin
            arvalid = (c == 0);
            awvalid = (c == 4);
            wvalid  = (c == 4);
            rready  = (c == 9);
            check("t3_arready", arready, (c == 0 || c == 10) ? 1 : 0);
            check("t3_rd_en", rd_en, (c == 1) ? 1 : 0);
            check("t3_rvalid", rvalid, (c >= 4 && c <= 9) ? 1 : 0);
            check("t3_wr_en", wr_en, (c == 5) ? 1 : 0);
            check("t3_bvalid", bvalid, (c == 6) ? 1 : 0);
            if (c == 1) check("t3_rd_addr", rd_addr, 8);
            if (c >= 4 && c <= 9) begin
                check("t3_rdata", rdata, 32'h12345678);
                check("t3_rresp", rresp, 2'b00);
            end
            step();
        end
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0; rready = 1'b0; bready = 1'b0;
        exp_rd_cnt++;
        model_write(32'h4, 32'h0BADCAFE, 4'hF);

        // ---- out-of-range write and read ----
        axi_write(32'h40, 32'hFFFFFFFF, 4'hF, 1, 0, 2'b10);
        model_write(32'h40, 32'hFFFFFFFF, 4'hF);
        axi_read(32'h40, 2, 32'h0, 2'b10);
        check("oor_wr_en_count", wr_cnt, exp_wr_cnt);
        check("oor_rd_en_count", rd_cnt, exp_rd_cnt);

        // ---- reset during RWait ----
        araddr = 32'h20; arvalid = 1'b1;
        check("t6_arready_c0", arready, 1);
        step();
        arvalid = 1'b0;
        check("t6_rd_en_c1", rd_en, 1);
        exp_rd_cnt++;
        step();
        arst_ni = 1'b0;
        #1;
        check("t6_rvalid_in_reset", rvalid, 0);
        check("t6_arready_in_reset", arready, 0);
        step(); step();
        arst_ni = 1'b1;
        check("t6_arready_at_release", arready, 0);
        step();
        check("t6_arready_after_release", arready, 1);
        for (int c = 0; c < 8; c++) begin
            check("t6_rvalid_quiet", rvalid, 0);
            check("t6_rdata_quiet", rdata, 0);
            step();
        end
        check("t6_rd_en_count", rd_cnt, exp_rd_cnt);

        // ---- randomized traffic against the reference memory ----
        for (int it = 0; it < 60; it++) begin
            word = $urandom_range(0, NUM_WORDS + 3);
            a = (word << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                s = 4'($urandom_range(0, 15));
                axi_write(a, d, s, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), model_resp(a));
                model_write(a, d, s);
            end else begin
                axi_read(a, int'($urandom_range(0, 3)), model_read(a), model_resp(a));
                if (model_in_range(a)) exp_rd_cnt++;
            end
        end
        for (int i = 0; i < NUM_WORDS; i++)
            axi_read(32'(i * 4), 0, ref_mem[i], 2'b00);
        exp_rd_cnt += NUM_WORDS;

        check("final_wr_en_count", wr_cnt, exp_wr_cnt);
        check("final_rd_en_count", rd_cnt, exp_rd_cnt);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
